pft_write_ctrl: RTL and testbench

- Upstream fill stage for the PFT bank memory.
- Accepts a valid/ready stream of PE_COL-wide rows, walks a bank/address counter and issues one-hot bank write strobes with a shared write address and data.
- Builds the per-bank valid mask that the bank memory uses to select real data or the 0x80 fill.
- Reports busy/done so the controller knows when the bank set may be read.

---
 rtl/pft_pkg.sv | 27 ++
 rtl/pft_bank_onehot.sv | 23 ++
 rtl/pft_write_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pft_write_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pft_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pft_pkg : shared widths, FSM state type and invalid-fill constant for PFT.
// Rev 1.0
// ----------------------------------------------------------------------------
package pft_pkg;

  localparam int PFT_DATA_W     = 8;
  localparam int PFT_PE_COL     = 16;
  localparam int PFT_NUM_BANK   = 32;
  localparam int PFT_ROW_W      = PFT_DATA_W * PFT_PE_COL;
  localparam int PFT_BANK_CNT_W = $clog2(PFT_NUM_BANK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } pft_state_e;

  // Row substituted by the bank memory for banks whose valid bit is clear.
  function automatic logic [PFT_ROW_W-1:0] pft_fill_row();
    return {PFT_PE_COL{8'h80}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pft_bank_onehot.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pft_bank_onehot : bank index to one-hot bank strobe vector (combinational).
// Rev 1.0
// ----------------------------------------------------------------------------
module pft_bank_onehot #(
  parameter int N     = 32,
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [N-1:0]     onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      onehot_o[i] = (idx_i == IDX_W'(i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/pft_write_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pft_write_ctrl : PFT bank fill stage; stream rows into one-hot bank writes.
// Optional macro PFT_WR_ROWMAJOR_EN selects row-major fill order.
// Rev 1.0
// ----------------------------------------------------------------------------
module pft_write_ctrl
  import pft_pkg::*;
#(
  parameter int PFT_addr_width = 5,
  parameter int PFT_data_width = PFT_DATA_W,
  parameter int PE_COL         = PFT_PE_COL,
  parameter int PFT_bank       = PFT_NUM_BANK
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic [$clog2(PFT_bank):0]          cfg_banks,
  input  logic [PFT_addr_width:0]            cfg_rows,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [PFT_data_width*PE_COL-1:0]   in_data,
  output logic [PFT_bank-1:0]                write,
  output logic [PFT_addr_width-1:0]          PFT_waddr,
  output logic [PFT_data_width*PE_COL-1:0]   din,
  output logic [PFT_bank-1:0]                valid,
  output logic                               busy,
  output logic                               done
);

  localparam int ROW_W    = PFT_data_width * PE_COL;
  localparam int BCNT_W   = $clog2(PFT_bank);
  localparam int CFG_BW   = BCNT_W + 1;
  localparam int CFG_RW   = PFT_addr_width + 1;
  localparam int ROWS_MAX = 1 << PFT_addr_width;

  pft_state_e                 state_q, state_d;
  logic [CFG_BW-1:0]          banks_q, banks_d;
  logic [CFG_RW-1:0]          rows_q, rows_d;
  logic [BCNT_W-1:0]          bank_cnt_q, bank_cnt_d;
  logic [PFT_addr_width-1:0]  row_cnt_q, row_cnt_d;
  logic [PFT_bank-1:0]        write_q, write_d;
  logic [PFT_addr_width-1:0]  waddr_q, waddr_d;
  logic [ROW_W-1:0]           din_q, din_d;
  logic [PFT_bank-1:0]        valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic [PFT_bank-1:0]        bank_oh;
  logic [CFG_BW-1:0]          banks_clamp;
  logic [CFG_RW-1:0]          rows_clamp;
  logic                       accept;
  logic                       row_last;
  logic                       bank_last;

  pft_bank_onehot #(
    .N     (PFT_bank),
    .IDX_W (BCNT_W)
  ) u_bank_onehot (
    .idx_i    (bank_cnt_q),
    .onehot_o (bank_oh)
  );

  assign banks_clamp = (cfg_banks > CFG_BW'(PFT_bank)) ? CFG_BW'(PFT_bank) : cfg_banks;
  assign rows_clamp  = (cfg_rows > CFG_RW'(ROWS_MAX)) ? CFG_RW'(ROWS_MAX) : cfg_rows;

  assign in_ready  = (state_q == FILL);
  assign accept    = in_valid && in_ready;
  assign row_last  = ({1'b0, row_cnt_q} == (rows_q - CFG_RW'(1)));
  assign bank_last = ({1'b0, bank_cnt_q} == (banks_q - CFG_BW'(1)));

`ifdef PFT_WR_ROWMAJOR_EN
  logic [PFT_bank-1:0] bank_mask;

  always_comb begin
    bank_mask = '0;
    for (int i = 0; i < PFT_bank; i++) begin
      bank_mask[i] = (CFG_BW'(i) < banks_q);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    banks_d    = banks_q;
    rows_d     = rows_q;
    bank_cnt_d = bank_cnt_q;
    row_cnt_d  = row_cnt_q;
    write_d    = '0;
    waddr_d    = waddr_q;
    din_d      = din_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // A start landing on the done cycle is dropped on purpose.
        if (start && !done_q) begin
          banks_d    = banks_clamp;
          rows_d     = rows_clamp;
          bank_cnt_d = '0;
          row_cnt_d  = '0;
          valid_d    = '0;
          busy_d     = 1'b1;
          state_d    = ((cfg_banks == '0) || (cfg_rows == '0)) ? FLUSH : FILL;
        end
      end

      FILL: begin
        if (accept) begin
          write_d = bank_oh;
          waddr_d = row_cnt_q;
          din_d   = in_data;
`ifdef PFT_WR_ROWMAJOR_EN
          if (bank_last) begin
            bank_cnt_d = '0;
            row_cnt_d  = row_cnt_q + PFT_addr_width'(1);
          end else begin
            bank_cnt_d = bank_cnt_q + BCNT_W'(1);
          end
          if (bank_last && row_last) begin
            valid_d = bank_mask;
            state_d = FLUSH;
          end
`else
          if (row_last) begin
            row_cnt_d  = '0;
            bank_cnt_d = bank_cnt_q + BCNT_W'(1);
            valid_d    = valid_q | bank_oh;
          end else begin
            row_cnt_d  = row_cnt_q + PFT_addr_width'(1);
          end
          if (row_last && bank_last) begin
            state_d = FLUSH;
          end
`endif
        end
      end

      FLUSH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      banks_q    <= '0;
      rows_q     <= '0;
      bank_cnt_q <= '0;
      row_cnt_q  <= '0;
      write_q    <= '0;
      waddr_q    <= '0;
      din_q      <= '0;
      valid_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      banks_q    <= banks_d;
      rows_q     <= rows_d;
      bank_cnt_q <= bank_cnt_d;
      row_cnt_q  <= row_cnt_d;
      write_q    <= write_d;
      waddr_q    <= waddr_d;
      din_q      <= din_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign write     = write_q;
  assign PFT_waddr = waddr_q;
  assign din       = din_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pft_write_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pft_write_ctrl : scoreboard bench for pft_write_ctrl (directed + random).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pft_write_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int PC    = 16;
  localparam int NB    = 32;
  localparam int ROW_W = DW * PC;
  localparam int CBW   = $clog2(NB) + 1;
  localparam int RW    = AW + 1;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [CBW-1:0]    cfg_banks = '0;
  logic [RW-1:0]     cfg_rows = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ROW_W-1:0]  in_data = '0;
  logic [NB-1:0]     write;
  logic [AW-1:0]     PFT_waddr;
  logic [ROW_W-1:0]  din;
  logic [NB-1:0]     valid;
  logic              busy;
  logic              done;

  pft_write_ctrl #(
    .PFT_addr_width (AW),
    .PFT_data_width (DW),
    .PE_COL         (PC),
    .PFT_bank       (NB)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .cfg_banks (cfg_banks),
    .cfg_rows  (cfg_rows),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .write     (write),
    .PFT_waddr (PFT_waddr),
    .din       (din),
    .valid     (valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0]    wr;
    logic [AW-1:0]    addr;
    logic [ROW_W-1:0] data;
    logic [NB-1:0]    vld;
    bit               last;
    int               due;
  } exp_t;

  exp_t sbq[$];
  int   cyc      = 0;
  int   total    = 0;
  int   bad      = 0;
  int   done_due = -1;
  int   done_cnt = 0;
  bit   mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NB-1:0] lowmask(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[NB-1:0];
  endfunction

  // Monitor: every cycle either a scheduled write appears or write is idle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        chk("write", ROW_W'(write), ROW_W'(e.wr));
        chk("waddr", ROW_W'(PFT_waddr), ROW_W'(e.addr));
        chk("din", din, e.data);
        chk("valid", ROW_W'(valid), ROW_W'(e.vld));
        if (e.last) done_due = cyc + 1;
      end else begin
        chk("no_write", ROW_W'(write), '0);
      end
      chk("done", ROW_W'(done), ROW_W'(cyc == done_due));
      if (done === 1'b1) done_cnt++;
    end
  end

  // vpat: 0 = in_valid held high, 1 = toggled, 2 = random.
  task automatic run_job(input int nb, input int nr, input int vpat,
                         input int restart_at, input int reset_at, input bit start_on_done);
    int               be, re, tot, k, guard, d0, bk, rw;
    logic [NB-1:0]    vm;
    logic [ROW_W-1:0] dat;
    bit               v;
    exp_t             e;
    be  = (nb > NB) ? NB : nb;
    re  = (nr > (1 << AW)) ? (1 << AW) : nr;
    tot = (be == 0 || re == 0) ? 0 : be * re;
    d0  = done_cnt;

    @(negedge clk);
    cfg_banks = CBW'(nb);
    cfg_rows  = RW'(nr);
    start     = 1'b1;
    if (tot == 0) done_due = cyc + 2;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", ROW_W'(busy), 1);

    k = 0;
    guard = 0;
    while (k < tot && guard < 4000) begin
      if (reset_at >= 0 && k == reset_at) begin
        rstn = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_write", ROW_W'(write), '0);
        chk("rst_valid", ROW_W'(valid), '0);
        chk("rst_busy", ROW_W'(busy), '0);
        chk("rst_in_ready", ROW_W'(in_ready), '0);
        sbq.delete();
        done_due = -1;
        rstn = 1'b1;
        return;
      end
      case (vpat)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      dat = {$urandom, $urandom, $urandom, $urandom};
      in_valid = v;
      in_data  = dat;
      if (k == restart_at) begin
        start     = 1'b1;
        cfg_banks = CBW'(1);
        cfg_rows  = RW'(1);
      end
      if (v && in_ready) begin
`ifdef PFT_WR_ROWMAJOR_EN
        bk = k % be;
        rw = k / be;
        vm = (k == tot - 1) ? lowmask(be) : '0;
`else
        bk = k / re;
        rw = k % re;
        vm = lowmask((k + 1) / re);
`endif
        e.wr   = NB'(1) << bk;
        e.addr = AW'(rw);
        e.data = dat;
        e.vld  = vm;
        e.last = (k == tot - 1);
        e.due  = cyc + 1;
        sbq.push_back(e);
        k++;
      end
      @(negedge clk);
      guard++;
      start = 1'b0;
    end
    in_valid = 1'b0;
    if (guard >= 4000) chk("beat_timeout", ROW_W'(k), ROW_W'(tot));

    guard = 0;
    while (done !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("done_seen", ROW_W'(done), 1);
    chk("busy_at_done", ROW_W'(busy), '0);
    chk("valid_final", ROW_W'(valid), ROW_W'((tot == 0) ? '0 : lowmask(be)));
    if (start_on_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("single_done", ROW_W'(done_cnt - d0), 1);
    chk("sb_empty", ROW_W'(sbq.size()), '0);
    if (start_on_done) begin
      chk("start_on_done_busy", ROW_W'(busy), '0);
      chk("start_on_done_ready", ROW_W'(in_ready), '0);
    end
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_write", ROW_W'(write), '0);
    chk("reset_waddr", ROW_W'(PFT_waddr), '0);
    chk("reset_din", din, '0);
    chk("reset_valid", ROW_W'(valid), '0);
    chk("reset_in_ready", ROW_W'(in_ready), '0);
    chk("reset_busy", ROW_W'(busy), '0);
    chk("reset_done", ROW_W'(done), '0);
    rstn   = 1'b1;
    mon_en = 1'b1;

    run_job(2, 3, 0, -1, -1, 1'b0);
    run_job(1, 4, 1, -1, -1, 1'b0);
    run_job(40, 0, 0, -1, -1, 1'b0);
    run_job(40, 1, 0, -1, -1, 1'b1);
    run_job(3, 2, 0, 2, -1, 1'b0);
    run_job(2, 4, 0, -1, 5, 1'b0);
    run_job(2, 4, 2, -1, -1, 1'b0);
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(1, 6), $urandom_range(1, 6), 2, -1, -1, j[0]);
    end
    run_job(0, 3, 0, -1, -1, 1'b0);
    run_job(3, 40, 2, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
